// File: rtl/data_sram_slave.sv
// rtl/data_sram_slave.sv - SRAM-like data slave with in-order outstanding response queue.
// Optional build macro: SRAM_SLAVE_RANDOM_DELAY_EN (LFSR-driven accept stalls and response holds).
module data_sram_slave #(
    parameter int DEPTH_LOG2  = 10,
    parameter int LATENCY     = 1,
    parameter int OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_sram_req,
    input  logic        data_sram_wr,
    input  logic [1:0]  data_sram_size,
    input  logic [3:0]  data_sram_wstrb,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic        data_sram_addr_ok,
    output logic        data_sram_data_ok,
    output logic [31:0] data_sram_rdata
);

    localparam int         WORDS    = 1 << DEPTH_LOG2;
    localparam logic [1:0] CNT_INIT = 2'(LATENCY - 1);
    localparam logic [1:0] MAX_OUT  = 2'(OUTSTANDING);

    logic [31:0]           mem    [WORDS];
    logic [31:0]           q_data [OUTSTANDING];
    logic [1:0]            q_cnt  [OUTSTANDING];
    logic                  head;
    logic                  tail;
    logic [1:0]            count;
    logic [DEPTH_LOG2-1:0] word_idx;
    logic [3:0]            lane_mask;
    logic [3:0]            byte_we;
    logic                  stall;
    logic                  hold;
    logic                  retire;
    logic                  accept;
    logic                  unused_addr;

    function automatic logic bump(input logic p);
        return (OUTSTANDING == 1) ? 1'b0 : !p;
    endfunction

`ifdef SRAM_SLAVE_RANDOM_DELAY_EN
    logic [15:0] lfsr;

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr <= 16'hACE1;
        end else begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    assign stall = (lfsr[1:0] == 2'b00);
    assign hold  = (lfsr[3:2] == 2'b00);
`else
    assign stall = 1'b0;
    assign hold  = 1'b0;
`endif

    // Upper address bits are don't-care: memory aliases modulo its size.
    assign word_idx    = data_sram_addr[DEPTH_LOG2+1:2];
    assign unused_addr = ^data_sram_addr[31:DEPTH_LOG2+2];

    always_comb begin
        lane_mask = 4'b1111;
        case (data_sram_size)
            2'd0:    lane_mask = 4'b0001 << data_sram_addr[1:0];
            2'd1:    lane_mask = data_sram_addr[1] ? 4'b1100 : 4'b0011;
            default: lane_mask = 4'b1111;
        endcase
    end

    assign byte_we = data_sram_wstrb & lane_mask;

    // The head may only leave once its own latency has elapsed; younger entries wait behind it.
    assign retire            = !reset && (count != 2'd0) && (q_cnt[head] == 2'd0) && !hold;
    assign data_sram_addr_ok = !reset && data_sram_req && ((count < MAX_OUT) || retire) && !stall;
    assign accept            = data_sram_req && data_sram_addr_ok;
    assign data_sram_data_ok = retire;
    assign data_sram_rdata   = retire ? q_data[head] : 32'd0;

    always_ff @(posedge clk) begin
        if (accept && data_sram_wr) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_we[b]) begin
                    mem[word_idx][8*b +: 8] <= data_sram_wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            q_data[tail] <= data_sram_wr ? 32'd0 : mem[word_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head  <= 1'b0;
            tail  <= 1'b0;
            count <= 2'd0;
            for (int i = 0; i < OUTSTANDING; i++) begin
                q_cnt[i] <= 2'd0;
            end
        end else begin
            for (int i = 0; i < OUTSTANDING; i++) begin
                if (q_cnt[i] != 2'd0) begin
                    q_cnt[i] <= q_cnt[i] - 2'd1;
                end
            end
            if (accept) begin
                q_cnt[tail] <= CNT_INIT;
                tail        <= bump(tail);
            end
            if (retire) begin
                head <= bump(head);
            end
            if (accept && !retire) begin
                count <= count + 2'd1;
            end else if (!accept && retire) begin
                count <= count - 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_data_sram_slave.sv
// tb/tb_data_sram_slave.sv - Directed and random checks of data_sram_slave against a byte-level memory model.
module tb_data_sram_slave;

    localparam int LAT = 3;
    localparam int OUT = 2;
    localparam int DL2 = 10;

    logic        clk;
    logic        reset;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    data_sram_slave #(.DEPTH_LOG2(DL2), .LATENCY(LAT), .OUTSTANDING(OUT)) dut (
        .clk               (clk),
        .reset             (reset),
        .data_sram_req     (req),
        .data_sram_wr      (wr),
        .data_sram_size    (size),
        .data_sram_wstrb   (wstrb),
        .data_sram_addr    (addr),
        .data_sram_wdata   (wdata),
        .data_sram_addr_ok (addr_ok),
        .data_sram_data_ok (data_ok),
        .data_sram_rdata   (rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  vmask;
        int          due;
    } exp_t;

    exp_t        eq[$];
    logic [31:0] mdl [1 << DL2];
    logic [3:0]  vld [1 << DL2];
    int          tests = 0;
    int          fails = 0;
    int          cyc   = 0;
    bit          acc;
    logic [31:0] last_rdata;
    logic [3:0]  aok_sh;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m32(input logic [3:0] m);
        return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
    endfunction

    // Model: a request of N bytes covers the naturally aligned N-byte block containing addr.
    task automatic model_accept();
        int   widx;
        int   nbytes;
        int   start;
        exp_t e;
        widx   = int'(addr >> 2) % (1 << DL2);
        nbytes = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        start  = (int'(addr % 4) / nbytes) * nbytes;
        e.due  = cyc + LAT;
        if (wr) begin
            for (int k = 0; k < 4; k++) begin
                if (k >= start && k < start + nbytes && wstrb[k]) begin
                    mdl[widx][8*k +: 8] = wdata[8*k +: 8];
                    vld[widx][k]        = 1'b1;
                end
            end
            e.data  = 32'd0;
            e.vmask = 4'hF;
        end else begin
            e.data  = mdl[widx];
            e.vmask = vld[widx];
        end
        eq.push_back(e);
    endtask

    task automatic step();
        bit   exp_dok;
        bit   allow_dok;
        exp_t e;
        acc = 1'b0;
        @(negedge clk);
        exp_dok   = (eq.size() > 0) && (eq[0].due == cyc);
        allow_dok = (eq.size() > 0) && (eq[0].due <= cyc);
`ifndef SRAM_SLAVE_RANDOM_DELAY_EN
        chk("data_ok", 32'(data_ok), 32'(exp_dok));
        chk("addr_ok", 32'(addr_ok), 32'(req && (eq.size() < OUT || exp_dok)));
`else
        chk("data_ok_early", 32'(data_ok && !allow_dok), 32'd0);
        chk("addr_ok_cap", 32'(addr_ok && !(req && (eq.size() < OUT || data_ok))), 32'd0);
`endif
        if (data_ok && eq.size() > 0) begin
            e          = eq.pop_front();
            last_rdata = rdata;
            chk("rdata", rdata & m32(e.vmask), e.data & m32(e.vmask));
        end
        aok_sh = {aok_sh[2:0], addr_ok};
        if (req && addr_ok) begin
            model_accept();
            acc = 1'b1;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic issue(input logic w, input logic [1:0] s, input logic [3:0] st,
                         input logic [31:0] a, input logic [31:0] d, output int n);
        req = 1'b1; wr = w; size = s; wstrb = st; addr = a; wdata = d;
        n = 0;
        acc = 1'b0;
        while (!acc && n < 64) begin
            step();
            n++;
        end
        if (!acc) chk("accept_timeout", 32'd0, 32'd1);
        req = 1'b0;
    endtask

    task automatic drain();
        int n;
        req = 1'b0;
        n = 0;
        while (eq.size() > 0 && n < 300) begin
            step();
            n++;
        end
        chk("drain_empty", 32'(eq.size()), 32'd0);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        req   = 1'b1;
        repeat (n) begin
            @(negedge clk);
            chk("rst_addr_ok", 32'(addr_ok), 32'd0);
            chk("rst_data_ok", 32'(data_ok), 32'd0);
            chk("rst_rdata", rdata, 32'd0);
            @(posedge clk);
            #1;
            cyc++;
        end
        reset = 1'b0;
        req   = 1'b0;
        eq.delete();
    endtask

    initial begin
        int n;
        for (int i = 0; i < (1 << DL2); i++) begin
            mdl[i] = 32'd0;
            vld[i] = 4'h0;
        end
        reset = 1'b1; req = 1'b0; wr = 1'b0; size = 2'd0; wstrb = 4'h0;
        addr = 32'd0; wdata = 32'd0; aok_sh = 4'h0; last_rdata = 32'd0;
        @(posedge clk);
        #1;
        do_reset(2);

        issue(1'b1, 2'd2, 4'hF, 32'h100, 32'h11223344, n);
`ifndef SRAM_SLAVE_RANDOM_DELAY_EN
        chk("wr_first_cycle_accept", 32'(n), 32'd1);
`endif
        issue(1'b0, 2'd2, 4'h0, 32'h100, 32'h0, n);
`ifndef SRAM_SLAVE_RANDOM_DELAY_EN
        chk("rd_first_cycle_accept", 32'(n), 32'd1);
`endif
        drain();
        chk("word_rw", last_rdata, 32'h11223344);

        issue(1'b1, 2'd2, 4'hF, 32'h100, 32'hFFFFFFFF, n);
        issue(1'b1, 2'd0, 4'hF, 32'h102, 32'h00AA0000, n);
        issue(1'b0, 2'd2, 4'h0, 32'h100, 32'h0, n);
        drain();
        chk("byte_merge", last_rdata, 32'hFFAAFFFF);

        aok_sh = 4'h0;
        issue(1'b0, 2'd2, 4'h0, 32'h100, 32'h0, n);
        issue(1'b0, 2'd2, 4'h0, 32'h104, 32'h0, n);
        issue(1'b0, 2'd2, 4'h0, 32'h108, 32'h0, n);
`ifndef SRAM_SLAVE_RANDOM_DELAY_EN
        chk("full_addr_ok_pattern", 32'(aok_sh), 32'(4'b1101));
`endif
        drain();

        issue(1'b0, 2'd2, 4'h0, 32'h100, 32'h0, n);
        issue(1'b0, 2'd2, 4'h0, 32'h104, 32'h0, n);
        do_reset(1);
        issue(1'b0, 2'd2, 4'h0, 32'h100, 32'h0, n);
        chk("post_reset_accept", 32'(n), 32'd1);
        repeat (8) step();
        chk("post_reset_read", last_rdata, 32'hFFAAFFFF);

        issue(1'b1, 2'd2, 4'hF, 32'h1000, 32'hCAFEF00D, n);
        issue(1'b0, 2'd2, 4'h0, 32'h0000, 32'h0, n);
        drain();
        chk("addr_wrap", last_rdata, 32'hCAFEF00D);

        for (int r = 0; r < 1000; r++) begin
            if ($urandom_range(0, 3) == 0) step();
            issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 4'($urandom),
                  (32'($urandom_range(0, 3)) << 12) | 32'($urandom_range(0, 63)), $urandom, n);
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
